dm_dmi_responder: RTL and testbench
===================================

# dm_dmi_responder

DMI responder at the Debug Module end of the DMI link, in the DM core clock domain after the CDC. Accepts one `dm::dmi_req_t` at a time, filters it by op and address, runs a single-beat access on a simple register port toward the DM register file, and returns a `dm::dmi_resp_t`. Exactly one request is outstanding at a time, which matches an initiator that waits for each response before issuing the next request.

## Interface
- `ADDR_LO`, default 7'h04: lowest DMI address forwarded to the register port.
- `ADDR_HI`, default 7'h40: highest forwarded DMI address, inclusive.
- `TIMEOUT_CYCLES`, default 16: register-port grant timeout. Legal range 1..255. Used only with `DM_DMI_TIMEOUT_EN`.
- `clk_i  in  1`: DM clock.
- `rst_ni  in  1`: reset. Synchronous, active-low.
- `dmi_clear_i  in  1`: synchronous abort/clear from the DTM side, already crossed into `clk_i`.
- `dmi_req_i  in  dm::dmi_req_t`: request fields `addr[6:0]`, `op`, `data[31:0]`.
- `dmi_req_valid_i  in  1`: request valid.
- `dmi_req_ready_o  out  1`: request ready.
- `dmi_resp_o  out  dm::dmi_resp_t`: response fields `data[31:0]`, `resp[1:0]`.
- `dmi_resp_valid_o  out  1`: response valid.
- `dmi_resp_ready_i  in  1`: response ready.
- `dm_busy_i  in  1`: DM core busy, e.g. an abstract command is running. While high, writes are refused.
- `reg_req_o  out  1`: register access request.
- `reg_we_o  out  1`: 1 = write, 0 = read.
- `reg_addr_o  out  7`: register address.
- `reg_wdata_o  out  32`: write data.
- `reg_gnt_i  in  1`: access complete; sampled while `reg_req_o` is high.
- `reg_rdata_i  in  32`: read data, valid with `reg_gnt_i`.
- `reg_err_i  in  1`: access error, valid with `reg_gnt_i`.

## Operation
- FSM states: `Idle`, `Access`, `Respond`. Reset state is `Idle`.
- Output reset values:
  - `dmi_req_ready_o`=1, `dmi_resp_valid_o`=0, `dmi_resp_o`='0.
  - `reg_req_o`=0, `reg_we_o`=0, `reg_addr_o`=0, `reg_wdata_o`=0.
- `dmi_req_ready_o` is 1 only in `Idle`. A request is accepted on `dmi_req_valid_i && dmi_req_ready_o`; `addr`, `op` and `data` are latched.
- Decode at acceptance, evaluated in this priority order:
  - `DTM_NOP` → `Respond`, resp `DTM_SUCCESS`, data 0.
  - Op value 3 (reserved) → `Respond`, resp `DTM_ERR`, data 0.
  - Address outside `ADDR_LO..ADDR_HI` → `Respond`, resp `DTM_ERR`, data 0.
  - `DTM_WRITE` with `dm_busy_i`=1 → `Respond`, resp `DTM_BUSY`, data 0. The register port is not touched.
  - Otherwise → `Access`.
- `Access`:
  - `reg_req_o`=1, with `reg_we_o`/`reg_addr_o`/`reg_wdata_o` from the latched request, held stable until grant.
  - On `reg_gnt_i`: `reg_err_i`=1 gives resp `DTM_ERR`, data 0.
  - Otherwise resp is `DTM_SUCCESS`, with data = `reg_rdata_i` for a read and data = 0 for a write.
  - Go to `Respond`.
- `Respond`:
  - `dmi_resp_valid_o`=1, and `dmi_resp_o` is held stable until `dmi_resp_ready_i`.
  - On the handshake cycle, go to `Idle`.
- `dmi_clear_i`:
  - Forces `Idle` in any state on the next edge.
  - Drops any pending response and deasserts `reg_req_o`.
  - Clears the response register to 0.
  - No request is accepted in a cycle where `dmi_clear_i`=1.

## Timing
- Acceptance in cycle N → `reg_req_o` high in N+1.
- With a same-cycle grant in N+1, `dmi_resp_valid_o` is high in N+2. Minimum forwarded latency is 2 cycles.
- Filtered requests (NOP, reserved, out of range, busy) show `dmi_resp_valid_o` in N+1.
- With `dmi_resp_ready_i` held at 1, `Respond` lasts one cycle and `Idle` follows in the next cycle. Back-to-back requests therefore need at least 3 cycles each.
- `reg_gnt_i` is ignored outside `Access`.
- `dm_busy_i` is sampled only in the acceptance cycle.
- Reset has priority over `dmi_clear_i`; `dmi_clear_i` has priority over all handshakes.

## Configuration
- With `DM_DMI_TIMEOUT_EN` defined:
  - An 8-bit counter clears on entry to `Access` and increments every cycle spent in `Access`.
  - When the counter reaches `TIMEOUT_CYCLES - 1` without a grant, the next cycle drops `reg_req_o`, goes to `Respond`, and returns resp `DTM_ERR` with data 32'hB051B051.
  - A grant in the same cycle as expiry wins over the timeout.
- Without the macro: no counter; `Access` waits indefinitely for `reg_gnt_i`.

## Structure
- Package `dm` holds the shared definitions:
  - `dmi_req_t`, `dmi_resp_t`.
  - `dtm_op_e`: `DTM_NOP`=0, `DTM_READ`=1, `DTM_WRITE`=2.
  - Response codes: `DTM_SUCCESS`=0, `DTM_ERR`=2, `DTM_BUSY`=3.
- The FSM state enum is local to this module.
- Single module, no sub-modules. The timeout counter is inline.

## Test plan
- Read 7'h11, `reg_rdata_i`=32'hCAFE0001, grant on the first `Access` cycle → resp `DTM_SUCCESS`, data 32'hCAFE0001, `dmi_resp_valid_o` 2 cycles after acceptance.
- Write 7'h10, data 32'h00000001, `dm_busy_i`=0 → `reg_we_o`=1, `reg_wdata_o`=32'h1, resp `DTM_SUCCESS`, data 0.
- Write 7'h17 with `dm_busy_i`=1 → `reg_req_o` never asserted, resp `DTM_BUSY` one cycle after acceptance.
- Read 7'h7F, then op 3 to 7'h10 → each gives resp `DTM_ERR`, data 0, and no register access.
- Read with `reg_gnt_i` stuck at 0, `TIMEOUT_CYCLES`=4, `DM_DMI_TIMEOUT_EN` defined → resp `DTM_ERR`, data 32'hB051B051, and `reg_req_o` drops after 4 cycles.
- `dmi_resp_ready_i`=0 for 5 cycles, then `dmi_clear_i` pulsed → the response stays stable through the stall, then `Idle` and `dmi_req_ready_o`=1 on the next cycle, with no response handshake.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared DMI request/response definitions for the Debug Module side of the DMI link.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dm;

    typedef enum logic [1:0] {
        DTM_NOP   = 2'd0,
        DTM_READ  = 2'd1,
        DTM_WRITE = 2'd2
    } dtm_op_e;

    localparam logic [1:0] DTM_SUCCESS = 2'd0;
    localparam logic [1:0] DTM_ERR     = 2'd2;
    localparam logic [1:0] DTM_BUSY    = 2'd3;

    typedef struct packed {
        logic [6:0]  addr;
        dtm_op_e     op;
        logic [31:0] data;
    } dmi_req_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } dmi_resp_t;

endpackage

// File: rtl/dm_dmi_responder.sv
// DMI responder: filters one DMI request at a time and runs a single-beat register access.
// Latency: filtered requests respond 1 cycle after acceptance, forwarded ones 2+ cycles (grant dependent).
// Backpressure: req ready only in Idle; response held until resp ready. DM_DMI_TIMEOUT_EN adds a grant timeout.
module dm_dmi_responder
    import dm::*;
#(
    parameter logic [6:0]  ADDR_LO        = 7'h04,
    parameter logic [6:0]  ADDR_HI        = 7'h40,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        dmi_clear_i,
    input  dmi_req_t    dmi_req_i,
    input  logic        dmi_req_valid_i,
    output logic        dmi_req_ready_o,
    output dmi_resp_t   dmi_resp_o,
    output logic        dmi_resp_valid_o,
    input  logic        dmi_resp_ready_i,
    input  logic        dm_busy_i,
    output logic        reg_req_o,
    output logic        reg_we_o,
    output logic [6:0]  reg_addr_o,
    output logic [31:0] reg_wdata_o,
    input  logic        reg_gnt_i,
    input  logic [31:0] reg_rdata_i,
    input  logic        reg_err_i
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_timeout_cycles_range
        $error("TIMEOUT_CYCLES must be within 1..255");
    end

    typedef enum logic [1:0] {
        Idle,
        Access,
        Respond
    } state_e;

    state_e    state_q, state_d;
    dmi_req_t  req_q, req_d;
    dmi_resp_t resp_q, resp_d;
    logic      accept;
    logic      out_of_range;

`ifdef DM_DMI_TIMEOUT_EN
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] cnt_q, cnt_d;
`endif

    assign accept       = dmi_req_valid_i && !dmi_clear_i;
    assign out_of_range = (dmi_req_i.addr < ADDR_LO) || (dmi_req_i.addr > ADDR_HI);

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        resp_d  = resp_q;
`ifdef DM_DMI_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            Idle: begin
                if (accept) begin
                    req_d   = dmi_req_i;
                    resp_d  = '0;
                    state_d = Respond;
                    // Decode priority: NOP, reserved op, address range, busy write.
                    if (dmi_req_i.op == DTM_NOP) begin
                        resp_d.resp = DTM_SUCCESS;
                    end else if (logic'(&dmi_req_i.op)) begin
                        resp_d.resp = DTM_ERR;
                    end else if (out_of_range) begin
                        resp_d.resp = DTM_ERR;
                    end else if (dmi_req_i.op == DTM_WRITE && dm_busy_i) begin
                        resp_d.resp = DTM_BUSY;
                    end else begin
                        state_d = Access;
`ifdef DM_DMI_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end
                end
            end
            Access: begin
`ifdef DM_DMI_TIMEOUT_EN
                cnt_d = cnt_q + 8'd1;
`endif
                if (reg_gnt_i) begin
                    state_d     = Respond;
                    resp_d.resp = reg_err_i ? DTM_ERR : DTM_SUCCESS;
                    resp_d.data = (reg_err_i || req_q.op == DTM_WRITE) ? 32'h0 : reg_rdata_i;
                end
`ifdef DM_DMI_TIMEOUT_EN
                else if (cnt_q == TimeoutLast) begin
                    state_d     = Respond;
                    resp_d.resp = DTM_ERR;
                    resp_d.data = 32'hB051_B051;
                end
`endif
            end
            Respond: begin
                if (dmi_resp_ready_i) begin
                    state_d = Idle;
                end
            end
            default: state_d = Idle;
        endcase

        // Clear aborts everything in flight, including a pending response.
        if (dmi_clear_i) begin
            state_d = Idle;
            resp_d  = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= Idle;
            req_q   <= '0;
            resp_q  <= '0;
`ifdef DM_DMI_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            resp_q  <= resp_d;
`ifdef DM_DMI_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign dmi_req_ready_o  = (state_q == Idle);
    assign dmi_resp_valid_o = (state_q == Respond);
    assign dmi_resp_o       = resp_q;
    assign reg_req_o        = (state_q == Access);
    assign reg_we_o         = (req_q.op == DTM_WRITE);
    assign reg_addr_o       = req_q.addr;
    assign reg_wdata_o      = req_q.data;

endmodule

// File: tb/tb_dm_dmi_responder.sv
// Testbench for dm_dmi_responder: directed requests, expected responses queued and checked by a monitor.
module tb_dm_dmi_responder;
    import dm::*;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        dmi_clear_i = 1'b0;
    dmi_req_t    dmi_req_i;
    logic        dmi_req_valid_i = 1'b0;
    logic        dmi_req_ready_o;
    dmi_resp_t   dmi_resp_o;
    logic        dmi_resp_valid_o;
    logic        dmi_resp_ready_i = 1'b1;
    logic        dm_busy_i = 1'b0;
    logic        reg_req_o;
    logic        reg_we_o;
    logic [6:0]  reg_addr_o;
    logic [31:0] reg_wdata_o;
    logic        reg_gnt_i = 1'b0;
    logic [31:0] reg_rdata_i = 32'h0;
    logic        reg_err_i = 1'b0;

    int checks = 0;
    int errors = 0;
    dmi_resp_t exp_q[$];
    dmi_resp_t mon_e;

    dm_dmi_responder #(
        .ADDR_LO        (7'h04),
        .ADDR_HI        (7'h40),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .dmi_clear_i      (dmi_clear_i),
        .dmi_req_i        (dmi_req_i),
        .dmi_req_valid_i  (dmi_req_valid_i),
        .dmi_req_ready_o  (dmi_req_ready_o),
        .dmi_resp_o       (dmi_resp_o),
        .dmi_resp_valid_o (dmi_resp_valid_o),
        .dmi_resp_ready_i (dmi_resp_ready_i),
        .dm_busy_i        (dm_busy_i),
        .reg_req_o        (reg_req_o),
        .reg_we_o         (reg_we_o),
        .reg_addr_o       (reg_addr_o),
        .reg_wdata_o      (reg_wdata_o),
        .reg_gnt_i        (reg_gnt_i),
        .reg_rdata_i      (reg_rdata_i),
        .reg_err_i        (reg_err_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%b want=%b", name, act, exp);
        end
    endtask

    // Monitor: every response handshake is matched against the scoreboard.
    always @(negedge clk_i) begin
        if (rst_ni && dmi_resp_valid_o && dmi_resp_ready_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL resp_unexpected got data=%h resp=%0d want no response",
                         dmi_resp_o.data, dmi_resp_o.resp);
            end else begin
                mon_e = exp_q.pop_front();
                chk("resp_data", dmi_resp_o.data, mon_e.data);
                chk("resp_code", {30'h0, dmi_resp_o.resp}, {30'h0, mon_e.resp});
            end
        end
    end

    task automatic expect_resp(input logic [31:0] d, input logic [1:0] r);
        dmi_resp_t e;
        e.data = d;
        e.resp = r;
        exp_q.push_back(e);
    endtask

    // Called at 1 time unit after a rising edge; returns 1 unit after the acceptance edge.
    task automatic send(input logic [6:0] a, input logic [1:0] op, input logic [31:0] d);
        int w = 0;
        while (dmi_req_ready_o !== 1'b1 && w < 20) begin
            @(posedge clk_i); #1;
            w++;
        end
        if (w >= 20) begin
            checks++;
            errors++;
            $display("FAIL send_wait got ready=%b want 1 within 20 cycles", dmi_req_ready_o);
        end
        dmi_req_i       = {a, op, d};
        dmi_req_valid_i = 1'b1;
        @(posedge clk_i); #1;
        dmi_req_valid_i = 1'b0;
    endtask

    task automatic filtered(input string name, input logic [6:0] a, input logic [1:0] op,
                            input logic [1:0] r);
        expect_resp(32'h0, r);
        send(a, op, 32'hDEAD_0000);
        @(negedge clk_i);
        chk1({name, "_vld_n1"}, dmi_resp_valid_o, 1'b1);
        chk1({name, "_noreq"}, reg_req_o, 1'b0);
        @(posedge clk_i); #1;
    endtask

    task automatic forwarded(input string name, input logic [6:0] a, input logic [1:0] op,
                             input logic [31:0] d, input logic [31:0] rdata, input logic err,
                             input logic [31:0] exp_d, input logic [1:0] exp_r);
        reg_gnt_i   = 1'b1;
        reg_rdata_i = rdata;
        reg_err_i   = err;
        expect_resp(exp_d, exp_r);
        send(a, op, d);
        @(negedge clk_i);
        chk1({name, "_req_n1"}, reg_req_o, 1'b1);
        chk1({name, "_vld_n1"}, dmi_resp_valid_o, 1'b0);
        chk1({name, "_we"}, reg_we_o, op == 2'd2);
        chk({name, "_addr"}, {25'h0, reg_addr_o}, {25'h0, a});
        chk({name, "_wdata"}, reg_wdata_o, d);
        @(negedge clk_i);
        chk1({name, "_vld_n2"}, dmi_resp_valid_o, 1'b1);
        @(posedge clk_i); #1;
        reg_gnt_i = 1'b0;
        reg_err_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got no finish want finish before 200000");
        $fatal(1);
    end

    initial begin
        dmi_req_i = '0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk1("rst_ready", dmi_req_ready_o, 1'b1);
        chk1("rst_vld", dmi_resp_valid_o, 1'b0);
        chk("rst_resp", dmi_resp_o.data, 32'h0);
        chk1("rst_req", reg_req_o, 1'b0);
        chk1("rst_we", reg_we_o, 1'b0);
        chk({"rst_", "addr"}, {25'h0, reg_addr_o}, 32'h0);
        chk("rst_wdata", reg_wdata_o, 32'h0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

        forwarded("rd11", 7'h11, 2'd1, 32'h0, 32'hCAFE_0001, 1'b0, 32'hCAFE_0001, DTM_SUCCESS);
        forwarded("wr10", 7'h10, 2'd2, 32'h0000_0001, 32'h7777_7777, 1'b0, 32'h0, DTM_SUCCESS);
        forwarded("rd04", 7'h04, 2'd1, 32'h0, 32'h0000_0404, 1'b0, 32'h0000_0404, DTM_SUCCESS);
        forwarded("rd40", 7'h40, 2'd1, 32'h0, 32'h0000_4040, 1'b0, 32'h0000_4040, DTM_SUCCESS);
        forwarded("rderr", 7'h20, 2'd1, 32'h0, 32'hFFFF_FFFF, 1'b1, 32'h0, DTM_ERR);

        dm_busy_i = 1'b1;
        filtered("busy_wr17", 7'h17, 2'd2, DTM_BUSY);
        forwarded("busy_rd17", 7'h17, 2'd1, 32'h0, 32'h0000_1717, 1'b0, 32'h0000_1717, DTM_SUCCESS);
        dm_busy_i = 1'b0;

        filtered("rd7f", 7'h7F, 2'd1, DTM_ERR);
        filtered("op3", 7'h10, 2'd3, DTM_ERR);
        filtered("nop7f", 7'h7F, 2'd0, DTM_SUCCESS);
        filtered("rd03", 7'h03, 2'd1, DTM_ERR);
        filtered("rd41", 7'h41, 2'd1, DTM_ERR);

        // Late grant on the fourth Access cycle.
        reg_gnt_i   = 1'b0;
        reg_rdata_i = 32'h0000_1234;
        expect_resp(32'h0000_1234, DTM_SUCCESS);
        send(7'h20, 2'd1, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk1("slow_req", reg_req_o, 1'b1);
            chk({"slow_", "addr"}, {25'h0, reg_addr_o}, 32'h20);
        end
        @(posedge clk_i); #1;
        reg_gnt_i = 1'b1;
        @(posedge clk_i); #1;
        reg_gnt_i = 1'b0;
        @(negedge clk_i);
        chk1("slow_vld", dmi_resp_valid_o, 1'b1);
        @(posedge clk_i); #1;

`ifdef DM_DMI_TIMEOUT_EN
        begin
            int n = 0;
            int w = 0;
            reg_gnt_i = 1'b0;
            expect_resp(32'hB051_B051, DTM_ERR);
            send(7'h21, 2'd1, 32'h0);
            while (dmi_resp_valid_o !== 1'b1 && w < 40) begin
                @(negedge clk_i);
                if (reg_req_o) n++;
                w++;
            end
            chk("to_req_cycles", 32'(n), 32'd4);
            chk1("to_vld", dmi_resp_valid_o, 1'b1);
            @(posedge clk_i); #1;
        end
`endif

        // Stalled response, then aborted by clear with no handshake.
        dmi_resp_ready_i = 1'b0;
        reg_gnt_i        = 1'b1;
        reg_rdata_i      = 32'hA5A5_0012;
        send(7'h12, 2'd1, 32'h0);
        @(negedge clk_i);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            chk1("stall_vld", dmi_resp_valid_o, 1'b1);
            chk("stall_data", dmi_resp_o.data, 32'hA5A5_0012);
            chk("stall_code", {30'h0, dmi_resp_o.resp}, {30'h0, DTM_SUCCESS});
        end
        @(posedge clk_i); #1;
        reg_gnt_i   = 1'b0;
        dmi_clear_i = 1'b1;
        @(posedge clk_i); #1;
        dmi_clear_i = 1'b0;
        @(negedge clk_i);
        chk1("clr_ready", dmi_req_ready_o, 1'b1);
        chk1("clr_vld", dmi_resp_valid_o, 1'b0);
        chk("clr_resp", dmi_resp_o.data, 32'h0);
        dmi_resp_ready_i = 1'b1;
        @(posedge clk_i); #1;

        // A request presented together with clear in Idle is not taken.
        dmi_req_i       = {7'h11, 2'd1, 32'h0};
        dmi_req_valid_i = 1'b1;
        dmi_clear_i     = 1'b1;
        @(posedge clk_i); #1;
        dmi_req_valid_i = 1'b0;
        dmi_clear_i     = 1'b0;
        @(negedge clk_i);
        chk1("clr_noacc_ready", dmi_req_ready_o, 1'b1);
        chk1("clr_noacc_req", reg_req_o, 1'b0);
        @(posedge clk_i); #1;

        forwarded("post_clr", 7'h3F, 2'd1, 32'h0, 32'h0BAD_F00D, 1'b0, 32'h0BAD_F00D, DTM_SUCCESS);

        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
